// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with operand forwarding from EX, MEM and WB.
// It also detects load-use hazards and counts the stall cycles they cause.
module id_ex_forward #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Clrn,
  input  logic         D_Valid,
  input  logic [4:0]   D_Ra,
  input  logic [4:0]   D_Rb,
  input  logic         D_UseA,
  input  logic         D_UseB,
  input  logic [W-1:0] D_Qa,
  input  logic [W-1:0] D_Qb,
  input  logic [W-1:0] D_Imm,
  input  logic [4:0]   D_Rd,
  input  logic         D_Wreg,
  input  logic         D_M2reg,
  input  logic         D_Wmem,
  input  logic         D_Aluimm,
  input  logic [3:0]   D_Aluc,
  input  logic         Flush,
  input  logic [W-1:0] Ex_Alu,
  input  logic [4:0]   M_Rd,
  input  logic         M_Wreg,
  input  logic         M_M2reg,
  input  logic [W-1:0] M_Alu,
  input  logic [W-1:0] M_Mem,
  input  logic [4:0]   W_Rd,
  input  logic         W_Wreg,
  input  logic [W-1:0] W_D,
  output logic         Stall,
  output logic         E_Valid,
  output logic         E_Wreg,
  output logic         E_M2reg,
  output logic         E_Wmem,
  output logic         E_Aluimm,
  output logic [3:0]   E_Aluc,
  output logic [4:0]   E_Rd,
  output logic [W-1:0] E_Qa,
  output logic [W-1:0] E_Qb,
  output logic [W-1:0] E_Imm,
  output logic [15:0]  Stall_Cnt
);

  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic         hazard;
  logic         bubble;

  // A load still in EX has no data yet, so only non-load EX results forward.
  always_comb begin
    fwd_a = D_Qa;
    if (D_Ra == 5'd0)
      fwd_a = '0;
    else if (E_Valid && E_Wreg && !E_M2reg && (E_Rd == D_Ra))
      fwd_a = Ex_Alu;
    else if (M_Wreg && (M_Rd == D_Ra))
      fwd_a = M_M2reg ? M_Mem : M_Alu;
    else if (W_Wreg && (W_Rd == D_Ra))
      fwd_a = W_D;
  end

  always_comb begin
    fwd_b = D_Qb;
    if (D_Rb == 5'd0)
      fwd_b = '0;
    else if (E_Valid && E_Wreg && !E_M2reg && (E_Rd == D_Rb))
      fwd_b = Ex_Alu;
    else if (M_Wreg && (M_Rd == D_Rb))
      fwd_b = M_M2reg ? M_Mem : M_Alu;
    else if (W_Wreg && (W_Rd == D_Rb))
      fwd_b = W_D;
  end

  assign hazard = D_Valid && E_Valid && E_Wreg && E_M2reg && (E_Rd != 5'd0) &&
                  ((D_UseA && (D_Ra == E_Rd)) || (D_UseB && (D_Rb == E_Rd)));
  assign Stall  = hazard && !Flush;
  assign bubble = Flush || Stall || !D_Valid;

  always_ff @(posedge Clk) begin
    if (!Clrn || bubble) begin
      E_Valid  <= 1'b0;
      E_Wreg   <= 1'b0;
      E_M2reg  <= 1'b0;
      E_Wmem   <= 1'b0;
      E_Aluimm <= 1'b0;
      E_Aluc   <= '0;
      E_Rd     <= '0;
      E_Qa     <= '0;
      E_Qb     <= '0;
      E_Imm    <= '0;
    end else begin
      E_Valid  <= 1'b1;
      E_Wreg   <= D_Wreg;
      E_M2reg  <= D_M2reg;
      E_Wmem   <= D_Wmem;
      E_Aluimm <= D_Aluimm;
      E_Aluc   <= D_Aluc;
      E_Rd     <= D_Rd;
      E_Qa     <= fwd_a;
      E_Qb     <= fwd_b;
      E_Imm    <= D_Imm;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn)
      Stall_Cnt <= '0;
    else if (Stall && (Stall_Cnt != 16'hFFFF))
      Stall_Cnt <= Stall_Cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_forward.sv
// Self-checking bench for id_ex_forward: directed scenarios, a randomized phase
// against a behavioural model, and counter saturation.
module tb_id_ex_forward;

  logic        Clk = 1'b0;
  logic        Clrn, D_Valid, D_UseA, D_UseB, D_Wreg, D_M2reg, D_Wmem, D_Aluimm, Flush;
  logic [4:0]  D_Ra, D_Rb, D_Rd, M_Rd, W_Rd;
  logic [31:0] D_Qa, D_Qb, D_Imm, Ex_Alu, M_Alu, M_Mem, W_D;
  logic [3:0]  D_Aluc;
  logic        M_Wreg, M_M2reg, W_Wreg;
  logic        Stall, E_Valid, E_Wreg, E_M2reg, E_Wmem, E_Aluimm;
  logic [3:0]  E_Aluc;
  logic [4:0]  E_Rd;
  logic [31:0] E_Qa, E_Qb, E_Imm;
  logic [15:0] Stall_Cnt;

  int checks = 0;
  int errors = 0;

  // Model of the EX-stage contents and the stall counter
  logic        m_valid, m_wreg, m_m2reg, m_wmem, m_aluimm;
  logic [3:0]  m_aluc;
  logic [4:0]  m_rd;
  logic [31:0] m_qa, m_qb, m_imm;
  logic [15:0] m_cnt;

  id_ex_forward #(.W(32)) dut (
    .Clk(Clk), .Clrn(Clrn), .D_Valid(D_Valid), .D_Ra(D_Ra), .D_Rb(D_Rb),
    .D_UseA(D_UseA), .D_UseB(D_UseB), .D_Qa(D_Qa), .D_Qb(D_Qb), .D_Imm(D_Imm),
    .D_Rd(D_Rd), .D_Wreg(D_Wreg), .D_M2reg(D_M2reg), .D_Wmem(D_Wmem),
    .D_Aluimm(D_Aluimm), .D_Aluc(D_Aluc), .Flush(Flush), .Ex_Alu(Ex_Alu),
    .M_Rd(M_Rd), .M_Wreg(M_Wreg), .M_M2reg(M_M2reg), .M_Alu(M_Alu), .M_Mem(M_Mem),
    .W_Rd(W_Rd), .W_Wreg(W_Wreg), .W_D(W_D), .Stall(Stall), .E_Valid(E_Valid),
    .E_Wreg(E_Wreg), .E_M2reg(E_M2reg), .E_Wmem(E_Wmem), .E_Aluimm(E_Aluimm),
    .E_Aluc(E_Aluc), .E_Rd(E_Rd), .E_Qa(E_Qa), .E_Qb(E_Qb), .E_Imm(E_Imm),
    .Stall_Cnt(Stall_Cnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] modelOperand(input logic [4:0] r, input logic [31:0] q);
    if (r == 5'd0) return 32'd0;
    if (m_valid && m_wreg && !m_m2reg && m_rd == r) return Ex_Alu;
    if (M_Wreg && M_Rd == r) return M_M2reg ? M_Mem : M_Alu;
    if (W_Wreg && W_Rd == r) return W_D;
    return q;
  endfunction

  function automatic logic modelStall();
    logic reads_load;
    reads_load = (D_UseA && D_Ra == m_rd) || (D_UseB && D_Rb == m_rd);
    return D_Valid && m_valid && m_wreg && m_m2reg && m_rd != 5'd0 && reads_load && !Flush;
  endfunction

  task automatic modelClear();
    m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_aluimm = 0;
    m_aluc = '0; m_rd = '0; m_qa = '0; m_qb = '0; m_imm = '0; m_cnt = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic applyStimulus(input string tag);
    logic        st;
    logic [31:0] qa, qb;
    st = modelStall();
    qa = modelOperand(D_Ra, D_Qa);
    qb = modelOperand(D_Rb, D_Qb);
    #1 checkOutput({tag, ".stall"}, 32'(Stall), 32'(st));
    @(posedge Clk);
    if (!Clrn) begin
      modelClear();
    end else begin
      if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (Flush || st || !D_Valid) begin
        m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_aluimm = 0;
        m_aluc = '0; m_rd = '0; m_qa = '0; m_qb = '0; m_imm = '0;
      end else begin
        m_valid = 1; m_wreg = D_Wreg; m_m2reg = D_M2reg; m_wmem = D_Wmem;
        m_aluimm = D_Aluimm; m_aluc = D_Aluc; m_rd = D_Rd; m_qa = qa; m_qb = qb;
        m_imm = D_Imm;
      end
    end
    #1;
    checkOutput({tag, ".valid"},  32'(E_Valid),  32'(m_valid));
    checkOutput({tag, ".wreg"},   32'(E_Wreg),   32'(m_wreg));
    checkOutput({tag, ".m2reg"},  32'(E_M2reg),  32'(m_m2reg));
    checkOutput({tag, ".wmem"},   32'(E_Wmem),   32'(m_wmem));
    checkOutput({tag, ".aluimm"}, 32'(E_Aluimm), 32'(m_aluimm));
    checkOutput({tag, ".aluc"},   32'(E_Aluc),   32'(m_aluc));
    checkOutput({tag, ".rd"},     32'(E_Rd),     32'(m_rd));
    checkOutput({tag, ".qa"},     E_Qa,          m_qa);
    checkOutput({tag, ".qb"},     E_Qb,          m_qb);
    checkOutput({tag, ".imm"},    E_Imm,         m_imm);
    checkOutput({tag, ".cnt"},    32'(Stall_Cnt), 32'(m_cnt));
    @(negedge Clk);
  endtask

  task automatic quietInputs();
    D_Valid = 1; D_Ra = 0; D_Rb = 0; D_UseA = 0; D_UseB = 0;
    D_Qa = $urandom; D_Qb = $urandom; D_Imm = $urandom; D_Rd = 0;
    D_Wreg = 0; D_M2reg = 0; D_Wmem = 0; D_Aluimm = 0; D_Aluc = 4'($urandom);
    Flush = 0; Ex_Alu = $urandom; M_Rd = 0; M_Wreg = 0; M_M2reg = 0;
    M_Alu = $urandom; M_Mem = $urandom; W_Rd = 0; W_Wreg = 0; W_D = $urandom;
  endtask

  initial begin
    logic [15:0] cnt_before;
    modelClear();
    quietInputs();
    Clrn = 0;
    @(negedge Clk);

    // Reset held with a valid instruction in ID
    applyStimulus("reset1");
    applyStimulus("reset2");
    checkOutput("reset.cnt_zero", 32'(Stall_Cnt), 32'd0);
    Clrn = 1;

    // EX-to-ID forward, and EX wins over MEM
    D_Rd = 5; D_Wreg = 1; D_M2reg = 0;
    applyStimulus("alu_producer");
    D_Ra = 5; D_UseA = 1; D_Qa = 32'hDEAD; Ex_Alu = 32'h11;
    applyStimulus("alu_fwd");
    checkOutput("alu_fwd.literal", E_Qa, 32'h11);
    M_Wreg = 1; M_Rd = 5; M_Alu = 32'h22;
    applyStimulus("alu_over_mem");
    checkOutput("alu_over_mem.literal", E_Qa, 32'h11);

    // Load-use: one bubble, then forward from MEM load data
    quietInputs();
    D_Rd = 7; D_Wreg = 1; D_M2reg = 1;
    applyStimulus("load_issue");
    D_Rd = 8; D_Wreg = 1; D_M2reg = 0; D_Rb = 7; D_UseB = 1;
    applyStimulus("load_use_stall");
    checkOutput("load_use.valid_bubble", 32'(E_Valid), 32'd0);
    checkOutput("load_use.cnt_one", 32'(Stall_Cnt), 32'd1);
    M_Rd = 7; M_Wreg = 1; M_M2reg = 1; M_Mem = 32'hCAFE;
    applyStimulus("load_use_resume");
    checkOutput("load_use.qb_literal", E_Qb, 32'hCAFE);

    // WB forward and register 0
    quietInputs();
    W_Wreg = 1; W_Rd = 3; W_D = 32'h1234; D_Ra = 3; D_Qa = 0; D_UseA = 1;
    applyStimulus("wb_fwd");
    checkOutput("wb_fwd.literal", E_Qa, 32'h1234);
    D_Ra = 0; M_Rd = 0; M_Wreg = 1; M_Alu = 32'h55; W_Rd = 0; D_Qa = 32'h99;
    applyStimulus("r0");
    checkOutput("r0.literal", E_Qa, 32'd0);

    // Flush overrides a load-use hazard
    quietInputs();
    D_Rd = 9; D_Wreg = 1; D_M2reg = 1;
    applyStimulus("flush_load");
    cnt_before = Stall_Cnt;
    D_Ra = 9; D_UseA = 1; Flush = 1;
    applyStimulus("flush_hazard");
    checkOutput("flush.valid", 32'(E_Valid), 32'd0);
    checkOutput("flush.cnt_same", 32'(Stall_Cnt), 32'(cnt_before));

    // Randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 300; i++) begin
      Clrn = ($urandom_range(0, 39) != 0);
      D_Valid = ($urandom_range(0, 6) != 0);
      Flush = ($urandom_range(0, 9) == 0);
      D_Ra = 5'($urandom_range(0, 7)); D_Rb = 5'($urandom_range(0, 7));
      D_Rd = 5'($urandom_range(0, 7));
      D_UseA = 1'($urandom); D_UseB = 1'($urandom);
      D_Wreg = 1'($urandom); D_M2reg = 1'($urandom);
      D_Wmem = 1'($urandom); D_Aluimm = 1'($urandom); D_Aluc = 4'($urandom);
      D_Qa = $urandom; D_Qb = $urandom; D_Imm = $urandom; Ex_Alu = $urandom;
      M_Rd = 5'($urandom_range(0, 7)); M_Wreg = 1'($urandom); M_M2reg = 1'($urandom);
      M_Alu = $urandom; M_Mem = $urandom;
      W_Rd = 5'($urandom_range(0, 7)); W_Wreg = 1'($urandom); W_D = $urandom;
      applyStimulus($sformatf("rand%0d", i));
    end

    // Saturation: pin a load in EX so the hazard persists every cycle
    quietInputs();
    Clrn = 0;
    applyStimulus("sat_reset");
    Clrn = 1; D_Ra = 4; D_UseA = 1;
    force dut.E_Valid = 1'b1;
    force dut.E_Wreg = 1'b1;
    force dut.E_M2reg = 1'b1;
    force dut.E_Rd = 5'd4;
    for (int i = 0; i < 65534; i++) @(posedge Clk);
    #1;
    checkOutput("sat.stall", 32'(Stall), 32'd1);
    checkOutput("sat.cnt_fffe", 32'(Stall_Cnt), 32'h0000FFFE);
    @(posedge Clk); #1;
    checkOutput("sat.cnt_ffff", 32'(Stall_Cnt), 32'h0000FFFF);
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("sat.cnt_hold", 32'(Stall_Cnt), 32'h0000FFFF);
    Clrn = 0;
    @(negedge Clk);
    release dut.E_Valid;
    release dut.E_Wreg;
    release dut.E_M2reg;
    release dut.E_Rd;
    @(posedge Clk);
    @(negedge Clk);
    modelClear();
    applyStimulus("post_sat_reset");
    Clrn = 1;
    applyStimulus("post_sat_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
